// File: rtl/linebuf_window.sv
// linebuf_window: stores the last TAPS-1 video lines and emits a vertical
// TAPS-pixel column per written pixel. Optional macro: LINEBUF_EDGE_REPLICATE_EN.
module linebuf_window #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 640,
  parameter int TAPS   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_en,
  input  logic                     wr_en,
  input  logic                     shift_en,
  input  logic [DATA_W-1:0]        pix_in,
  output logic [TAPS*DATA_W-1:0]   tap_out,
  output logic                     tap_valid,
  output logic [2:0]               lines_filled,
  output logic                     overflow
);

  localparam int NL = TAPS - 1;
  localparam int AW = $clog2(LINE_W);
  localparam int HW = (NL > 1) ? $clog2(NL) : 1;
  localparam logic [2:0]    FULL    = 3'(NL);
  localparam logic [AW-1:0] WA_LAST = AW'(LINE_W - 1);
  localparam logic [HW-1:0] HP_LAST = HW'(NL - 1);

  logic [DATA_W-1:0] mem [NL][LINE_W];
  logic [DATA_W-1:0] rd  [NL];
  logic [AW-1:0]     wa;
  logic [HW-1:0]     hp;
  logic [HW-1:0]     hp_q;
  logic [2:0]        lf_q;
  logic [DATA_W-1:0] pix_q;
  logic              wrapped;
  logic              do_wr;

  // A write coinciding with frame_en (or reset) is dropped entirely.
  assign do_wr = wr_en & ~frame_en & ~rst;

  // Line RAMs: read every line at wa, then overwrite the head line.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < NL; i++) begin
        rd[i] <= mem[i][wa];
      end
      mem[hp][wa] <= pix_in;
    end
  end

  // Pointer, fill count, overflow and captured write context.
  always_ff @(posedge clk) begin
    if (rst) begin
      wa           <= '0;
      hp           <= '0;
      lines_filled <= '0;
      overflow     <= 1'b0;
      wrapped      <= 1'b0;
      tap_valid    <= 1'b0;
      pix_q        <= '0;
      hp_q         <= '0;
      lf_q         <= '0;
    end else begin
`ifdef LINEBUF_EDGE_REPLICATE_EN
      tap_valid <= do_wr;
`else
      tap_valid <= do_wr && (lines_filled == FULL);
`endif
      if (do_wr) begin
        pix_q <= pix_in;
        hp_q  <= hp;
        lf_q  <= lines_filled;
      end
      if (frame_en) begin
        wa           <= '0;
        hp           <= '0;
        lines_filled <= '0;
        overflow     <= 1'b0;
        wrapped      <= 1'b0;
      end else begin
        // A write after the address has already wrapped is an overrun.
        if (wr_en && wrapped) begin
          overflow <= 1'b1;
        end
        if (shift_en) begin
          wa      <= '0;
          wrapped <= 1'b0;
          hp      <= (hp == HP_LAST) ? '0 : hp + 1'b1;
          lines_filled <= (lines_filled == FULL) ? FULL
                                                 : lines_filled + 3'd1;
        end else if (wr_en) begin
          if (wa == WA_LAST) begin
            wa      <= '0;
            wrapped <= 1'b1;
          end else begin
            wa <= wa + 1'b1;
          end
        end
      end
    end
  end

  // Column assembly: slice k is the line k back, clamped or zeroed
  // when fewer than k lines are buffered.
  always_comb begin
    int kk;
    logic [HW-1:0] idx;
    tap_out = '0;
    kk      = 0;
    idx     = '0;
    for (int k = 0; k < TAPS; k++) begin
      kk = k;
`ifdef LINEBUF_EDGE_REPLICATE_EN
      if (kk > int'(lf_q)) kk = int'(lf_q);
`endif
      if (kk == 0) begin
        tap_out[k*DATA_W +: DATA_W] = pix_q;
      end else if (kk <= int'(lf_q)) begin
        idx = HW'((int'(hp_q) + NL - kk) % NL);
        tap_out[k*DATA_W +: DATA_W] = rd[idx];
      end
    end
  end

endmodule
